bin_to_bcd_seq: RTL and testbench

- Sequential double-dabble converter that sits directly downstream of the shift-add multiplier.
- Takes the multiplier's 8-bit product `pp` and converts it to packed BCD for the display/readout stage.
- Uses the same init/done handshake as the multiplier core, so the multiplier's `done` can drive this block's `init` directly.
- One bit is processed per two-cycle iteration (add-3 correction, then shift).

---
 rtl/bin_to_bcd_seq_if.sv | 23 ++
 rtl/bin_to_bcd_seq.sv | 125 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// ============================================================================
// Module   : bin_to_bcd_seq_if
// Brief    : Start/result bundle for the bin_to_bcd_seq double-dabble converter
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  init;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign;
  logic                  busy;
  logic                  done;

  modport master (output init, output bin, input bcd, input sign, input busy, input done);
  modport slave  (input init, input bin, output bcd, output sign, output busy, output done);
endinterface

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential double-dabble binary-to-packed-BCD converter, one bit
//            per add-3/shift pair. Optional macro BCD_SIGNED_EN treats the
//            input as two's complement and reports the sign separately.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  wire logic       clk,
  input  wire logic       rst,
  bin_to_bcd_seq_if.slave bus
);

  localparam int TOT = 4*DIGITS + WIDTH;
  localparam int CW  = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD3 = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [TOT-1:0]      r_scratch;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_busy;
  logic                r_done;
  logic [TOT-1:0]      w_add3;
  logic [TOT-1:0]      w_shifted;
  logic [WIDTH-1:0]    w_mag;

  // Per-digit +3 correction; digits are independent, no carry between them.
  always_comb begin
    w_add3 = r_scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scratch[WIDTH+4*d +: 4] >= 4'd5)
        w_add3[WIDTH+4*d +: 4] = r_scratch[WIDTH+4*d +: 4] + 4'd3;
    end
  end

  assign w_shifted = {r_scratch[TOT-2:0], 1'b0};

`ifdef BCD_SIGNED_EN
  logic r_sign;
  logic r_sign_lat;

  assign w_mag = bus.bin[WIDTH-1] ? (~bus.bin + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.bin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign     <= 1'b0;
      r_sign_lat <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.init)
        r_sign_lat <= bus.bin[WIDTH-1];
      if (r_state == S_SHIFT && r_cnt == CW'(1))
        r_sign <= r_sign_lat;
    end
  end

  assign bus.sign = r_sign;
`else
  assign w_mag    = bus.bin;
  assign bus.sign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.init) begin
            r_scratch <= {{(4*DIGITS){1'b0}}, w_mag};
            r_cnt     <= CW'(WIDTH);
            r_busy    <= 1'b1;
            r_state   <= S_ADD3;
          end
        end
        S_ADD3: begin
          r_scratch <= w_add3;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          r_scratch <= w_shifted;
          r_cnt     <= r_cnt - CW'(1);
          // Last bit: publish the result on the same edge as the final shift.
          if (r_cnt == CW'(1)) begin
            r_bcd   <= w_shifted[TOT-1:WIDTH];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ADD3;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bcd  = r_bcd;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Brief    : Directed self-checking bench for bin_to_bcd_seq (WIDTH=8, DIGITS=3)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;

  localparam bit SIGNED_MODE =
`ifdef BCD_SIGNED_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Start a conversion, optionally poke a spurious init at cycle 'poke', and
  // check latency, busy, result stability, result and sign.
  task automatic run(input string tag, input logic [7:0] b, input logic [11:0] eb,
                     input logic es, input int poke);
    int   n;
    int   lat;
    logic ok;
    logic [11:0] held;
    @(negedge clk);
    bus.init = 1'b1;
    bus.bin  = b;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.busy && n < 40);
    bus.init = 1'b0;
    bus.bin  = ~b;
    check({tag, "_accept"}, 32'(n < 40), 32'd1);
    held = bus.bcd;
    ok   = 1'b1;
    lat  = 0;
    while (!bus.done && lat < 40) begin
      if (lat == poke) begin
        bus.init = 1'b1;
        bus.bin  = 8'd7;
      end else begin
        bus.init = 1'b0;
      end
      @(posedge clk); #1; lat++;
      if (!bus.done && (!bus.busy || bus.bcd !== held)) ok = 1'b0;
    end
    bus.init = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd16);
    check({tag, "_busy_hold"}, 32'(ok), 32'd1);
    check({tag, "_bcd"}, 32'(bus.bcd), 32'(eb));
    check({tag, "_sign"}, 32'(bus.sign), 32'(es));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int extra;
    bus.init = 1'b0;
    bus.bin  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bcd",  32'(bus.bcd),  32'h0);
    check("rst_sign", 32'(bus.sign), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run("v255", 8'd255, SIGNED_MODE ? 12'h001 : 12'h255, SIGNED_MODE, -1);
    run("v0",   8'd0,   12'h000, 1'b0, -1);
    run("v99",  8'd99,  12'h099, 1'b0, -1);
    run("v100", 8'd100, 12'h100, 1'b0, -1);

    // Spurious init mid-conversion is ignored and yields no extra done.
    run("v200", 8'd200, SIGNED_MODE ? 12'h056 : 12'h200, SIGNED_MODE, 5);
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) extra++;
    end
    check("v200_no_extra_done", 32'(extra), 32'd0);
    check("v200_idle", 32'(bus.busy), 32'd0);

    // Asynchronous abort at cycle 6 of a conversion.
    @(negedge clk);
    bus.init = 1'b1;
    bus.bin  = 8'd173;
    @(posedge clk); #1;
    bus.init = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #3 rst = 1'b1;
    #1;
    check("abort_bcd",  32'(bus.bcd),  32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_done", 32'(bus.done), 32'h0);
    check("abort_sign", 32'(bus.sign), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) extra++;
    end
    check("abort_quiet", 32'(extra), 32'd0);

    run("v42",  8'd42, 12'h042, 1'b0, -1);
    // Multiplier product 13*11 = 143 fed straight in as pp.
    run("mul143", 8'd143, SIGNED_MODE ? 12'h113 : 12'h143, SIGNED_MODE, -1);
    run("v80",  8'h80, 12'h128, SIGNED_MODE, -1);
    run("vF9",  8'hF9, SIGNED_MODE ? 12'h007 : 12'h249, SIGNED_MODE, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
